// File: rtl/eth_fcs_framer.sv
// rtl/eth_fcs_framer.sv - Ethernet TX framer: preamble, frame bytes, zero padding, FCS from external CRC, IFG
module eth_fcs_framer #(
  parameter int PREAMBLE_EN = 1,
  parameter int MIN_FRAME   = 60,
  parameter int IFG_BYTES   = 12
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  input  logic        in_last,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        out_last,
  input  logic        out_ready,
  output logic [7:0]  crc_data,
  output logic        crc_en,
  output logic        crc_clr,
  input  logic [31:0] crc_value,
  output logic        busy
);

  typedef enum logic [2:0] {IDLE, PREAMBLE, DATA, PAD, FCS, IFG} state_t;

  localparam logic [11:0] MIN_LEN  = 12'(MIN_FRAME);
  localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES - 1);

  state_t      state, state_nxt;
  logic [2:0]  pre_idx, pre_idx_nxt;
  logic [10:0] count, count_nxt;
  logic [1:0]  fcs_idx, fcs_idx_nxt;
  logic [7:0]  ifg_cnt, ifg_cnt_nxt;
  logic [11:0] count_inc;
  logic [10:0] count_sat;

  // count_inc is unsaturated so the pad decision stays exact near the limit
  assign count_inc = {1'b0, count} + 12'd1;
  assign count_sat = (count == 11'h7FF) ? count : count + 11'd1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pre_idx <= '0;
      count   <= '0;
      fcs_idx <= '0;
      ifg_cnt <= '0;
    end else begin
      state   <= state_nxt;
      pre_idx <= pre_idx_nxt;
      count   <= count_nxt;
      fcs_idx <= fcs_idx_nxt;
      ifg_cnt <= ifg_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    pre_idx_nxt = pre_idx;
    count_nxt   = count;
    fcs_idx_nxt = fcs_idx;
    ifg_cnt_nxt = ifg_cnt;
    out_data    = 8'h00;
    out_valid   = 1'b0;
    out_last    = 1'b0;
    in_ready    = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid) state_nxt = (PREAMBLE_EN != 0) ? PREAMBLE : DATA;
      end
      PREAMBLE: begin
        out_valid = 1'b1;
        out_data  = (pre_idx == 3'd7) ? 8'hD5 : 8'h55;
        if (out_ready) begin
          pre_idx_nxt = pre_idx + 3'd1;
          if (pre_idx == 3'd7) state_nxt = DATA;
        end
      end
      DATA: begin
        out_data  = in_data;
        out_valid = in_valid;
        in_ready  = out_ready;
        if (in_valid && out_ready) begin
          count_nxt = count_sat;
          if (in_last) state_nxt = (count_inc < MIN_LEN) ? PAD : FCS;
        end
      end
      PAD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          count_nxt = count_sat;
          if (count_inc == MIN_LEN) state_nxt = FCS;
        end
      end
      FCS: begin
        out_valid = 1'b1;
        out_last  = (fcs_idx == 2'd3);
        case (fcs_idx)
          2'd0:    out_data = crc_value[7:0];
          2'd1:    out_data = crc_value[15:8];
          2'd2:    out_data = crc_value[23:16];
          default: out_data = crc_value[31:24];
        endcase
        if (out_ready) begin
          fcs_idx_nxt = fcs_idx + 2'd1;
          if (fcs_idx == 2'd3) state_nxt = IFG;
        end
      end
      IFG: begin
        if (ifg_cnt == IFG_LAST) begin
          ifg_cnt_nxt = '0;
          count_nxt   = '0;
          state_nxt   = IDLE;
        end else begin
          ifg_cnt_nxt = ifg_cnt + 8'd1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign crc_data = out_data;
  assign crc_en   = out_valid && out_ready && (state == DATA || state == PAD);
  assign crc_clr  = (state == IDLE) || (state == IFG);
  assign busy     = (state != IDLE);

endmodule
